mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-port arbiter that shares the single cache request port (`cpu_req_*` / `cpu_res_*` into the memory top) between an instruction-fetch requester and a data load/store requester. It serves one outstanding transaction at a time. Requests are registered toward the cache, and each cache completion is routed back to the requester that owns it. The data port has priority, bounded by a starvation counter that guarantees forward progress for instruction fetch. It sits in the `sys_clk` domain, directly in front of the memory top's CPU-side request inputs.

## Interface
- `ADDR_W`, 27, request address width.
- `DATA_W`, 32, request/response data width.
- `MAX_D_BURST`, 4, maximum consecutive data grants while the instruction port waits (≥1).

- `sys_clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_req_addr`  in  ADDR_W  instruction fetch address.
- `i_req_valid`  in  1  instruction request pending; level, held until `i_res_ready`.
- `i_res_data`  out  DATA_W  fetched word, valid while `i_res_ready`=1.
- `i_res_ready`  out  1  one-cycle completion pulse, instruction port.
- `d_req_addr`  in  ADDR_W  data address.
- `d_req_data`  in  DATA_W  write data.
- `d_req_rw`  in  1  1=write, 0=read.
- `d_req_valid`  in  1  data request pending; level, held until `d_res_ready`.
- `d_res_data`  out  DATA_W  read data, valid while `d_res_ready`=1.
- `d_res_ready`  out  1  one-cycle completion pulse, data port.
- `mem_req_addr`  out  ADDR_W  to cache request addr.
- `mem_req_data`  out  DATA_W  to cache request data.
- `mem_req_rw`  out  1  to cache request rw.
- `mem_req_valid`  out  1  to cache request valid.
- `mem_res_data`  in  DATA_W  cache response data.
- `mem_res_ready`  in  1  cache completion pulse.
- `grant_d`  out  1  current/last owner: 1=data, 0=instruction.

## Operation
- FSM states:
  - IDLE: sample requests.
  - BUSY_I, BUSY_D: request driven to cache.
  - GAP: one cycle with valid low, so the cache never sees back-to-back valid without a drop.
- IDLE selection:
  - Only `d_req_valid` set → BUSY_D.
  - Only `i_req_valid` set → BUSY_I.
  - Both set → BUSY_D, unless `starve_cnt == MAX_D_BURST`, then BUSY_I.
  - Neither set → stay in IDLE.
- Grant action:
  - The winner's addr/data/rw are latched into the `mem_req_*` registers, and `mem_req_valid` is set to 1.
  - The instruction grant forces `mem_req_rw`=0 and `mem_req_data`=0.
  - `grant_d` is updated.
- `starve_cnt` (width clog2(MAX_D_BURST+1)):
  - Increments on a D grant made while `i_req_valid`=1, saturating at MAX_D_BURST.
  - Clears on an I grant.
  - Clears in IDLE when `i_req_valid`=0.
- BUSY_x: `mem_req_*` are held stable until `mem_res_ready`=1. Then:
  - `mem_req_valid` is set to 0 and `x_res_data` is set to `mem_res_data`.
  - `x_res_ready` is set to 1 for exactly one cycle.
  - The FSM goes to GAP.
- GAP → IDLE unconditionally. Requests are not sampled in GAP.
- `mem_res_ready` in IDLE or GAP is ignored: no response pulse, no state change.
- The arbiter ignores requester input changes while BUSY, because the inputs were latched at grant.

## Timing
- All outputs are registered.
- Reset values:
  - `mem_req_*` = 0.
  - `i_res_*` = 0 and `d_res_*` = 0.
  - `grant_d` = 0, `starve_cnt` = 0.
  - State = IDLE.
- Grant latency: request valid in IDLE at cycle t → `mem_req_valid`=1 at t+1.
- Completion: `mem_res_ready`=1 at cycle u → at u+1:
  - `x_res_ready`=1 with data.
  - `mem_req_valid`=0.
  - State GAP.
- Next sample: IDLE at u+2, grant visible at u+3. Minimum turnaround between transactions is 3 cycles.
- Requester rule: after seeing `x_res_ready` at u+1, the requester presents its next request, or drops valid, by u+2.
- Asynchronous `rst` asserted mid-BUSY:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - The outstanding cache transaction is abandoned. The cache and DRAM path are reset by the same `rst`.
- Data width is passed through unchanged. There is no arithmetic on addr or data.

## Test plan
- Instruction read: `i_req_valid`=1, addr 0x0000100; cache returns `mem_res_ready` with 0xDEADBEEF 5 cycles after grant → `mem_req_valid`=1 and `rw`=0 one cycle after the request; `i_res_data`=0xDEADBEEF with a 1-cycle `i_res_ready`; `d_res_ready` stays 0.
- Data write: `d_req_rw`=1, addr 0x7FFFFFF, data 0x12345678 → `mem_req_*` carry exactly those values and are held stable until ready; `d_res_ready` pulses once; `mem_req_valid` is low for ≥1 cycle afterwards.
- Simultaneous: both valid in the same IDLE cycle, starve_cnt=0 → data granted first (`grant_d`=1); instruction granted 3 cycles after the data completion.
- Starvation: MAX_D_BURST=4, both ports held valid continuously, cache answers each in 2 cycles → grant order D,D,D,D,I,D,D,D,D,I.
- Stray `mem_res_ready` pulse in IDLE and in GAP → no `i_res_ready`/`d_res_ready`, state unchanged.
- `rst` asserted mid-BUSY_D between clock edges → all outputs 0 before the next edge; after release, a pending `i_req_valid` is granted normally.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: bundles the instruction port, data port and cache-side
// request/response signals of mem_req_arbiter.
//   i_req_* / i_res_*   : instruction-fetch requester (read only)
//   d_req_* / d_res_*   : data load/store requester
//   mem_req_* / mem_res_*: single request port into the cache
//   grant_d             : current/last owner, 1 = data, 0 = instruction
// slave modport is the arbiter view; master modport is the environment view.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_valid;
    logic [DATA_W-1:0] i_res_data;
    logic              i_res_ready;

    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_data;
    logic              d_req_rw;
    logic              d_req_valid;
    logic [DATA_W-1:0] d_res_data;
    logic              d_res_ready;

    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_rw;
    logic              mem_req_valid;
    logic [DATA_W-1:0] mem_res_data;
    logic              mem_res_ready;

    logic              grant_d;

    modport slave (
        input  i_req_addr, i_req_valid,
        input  d_req_addr, d_req_data, d_req_rw, d_req_valid,
        input  mem_res_data, mem_res_ready,
        output i_res_data, i_res_ready,
        output d_res_data, d_res_ready,
        output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
        output grant_d
    );

    modport master (
        output i_req_addr, i_req_valid,
        output d_req_addr, d_req_data, d_req_rw, d_req_valid,
        output mem_res_data, mem_res_ready,
        input  i_res_data, i_res_ready,
        input  d_res_data, d_res_ready,
        input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
        input  grant_d
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single cache request port between an
// instruction-fetch requester and a data load/store requester, one
// transaction at a time. Data has priority; after MAX_D_BURST consecutive
// data grants taken while instruction fetch waits, instruction fetch wins.
// Ports:
//   sys_clk : clock
//   rst     : asynchronous active-high reset
//   bus     : mem_req_arbiter_if.slave (requester, cache and grant signals)
// All outputs are registered.
module mem_req_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    mem_req_arbiter_if.slave     bus
);

    localparam int CNT_W = $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_BURST);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_rw_q, mem_rw_d;
    logic              mem_valid_q, mem_valid_d;
    logic              grant_d_q, grant_d_d;
    logic [DATA_W-1:0] i_res_data_q, i_res_data_d;
    logic              i_res_ready_q, i_res_ready_d;
    logic [DATA_W-1:0] d_res_data_q, d_res_data_d;
    logic              d_res_ready_q, d_res_ready_d;
    logic              d_wins;

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        mem_rw_d      = mem_rw_q;
        mem_valid_d   = mem_valid_q;
        grant_d_d     = grant_d_q;
        i_res_data_d  = i_res_data_q;
        d_res_data_d  = d_res_data_q;
        i_res_ready_d = 1'b0;
        d_res_ready_d = 1'b0;
        // Data wins unless instruction fetch has already waited out a full burst.
        d_wins = bus.d_req_valid && !(bus.i_req_valid && (starve_q == MAX_CNT));

        case (state_q)
            ST_IDLE: begin
                if (!bus.i_req_valid) begin
                    starve_d = '0;
                end
                if (d_wins) begin
                    mem_addr_d  = bus.d_req_addr;
                    mem_data_d  = bus.d_req_data;
                    mem_rw_d    = bus.d_req_rw;
                    mem_valid_d = 1'b1;
                    grant_d_d   = 1'b1;
                    state_d     = ST_BUSY_D;
                    // d_wins with i waiting implies starve_q < MAX_CNT, so no overflow.
                    if (bus.i_req_valid) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (bus.i_req_valid) begin
                    mem_addr_d  = bus.i_req_addr;
                    mem_data_d  = '0;
                    mem_rw_d    = 1'b0;
                    mem_valid_d = 1'b1;
                    grant_d_d   = 1'b0;
                    starve_d    = '0;
                    state_d     = ST_BUSY_I;
                end
            end
            ST_BUSY_I: begin
                if (bus.mem_res_ready) begin
                    mem_valid_d   = 1'b0;
                    i_res_data_d  = bus.mem_res_data;
                    i_res_ready_d = 1'b1;
                    state_d       = ST_GAP;
                end
            end
            ST_BUSY_D: begin
                if (bus.mem_res_ready) begin
                    mem_valid_d   = 1'b0;
                    d_res_data_d  = bus.mem_res_data;
                    d_res_ready_d = 1'b1;
                    state_d       = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_rw_q      <= 1'b0;
            mem_valid_q   <= 1'b0;
            grant_d_q     <= 1'b0;
            i_res_data_q  <= '0;
            i_res_ready_q <= 1'b0;
            d_res_data_q  <= '0;
            d_res_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_rw_q      <= mem_rw_d;
            mem_valid_q   <= mem_valid_d;
            grant_d_q     <= grant_d_d;
            i_res_data_q  <= i_res_data_d;
            i_res_ready_q <= i_res_ready_d;
            d_res_data_q  <= d_res_data_d;
            d_res_ready_q <= d_res_ready_d;
        end
    end

    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.mem_req_data  = mem_data_q;
    assign bus.mem_req_rw    = mem_rw_q;
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.grant_d       = grant_d_q;
    assign bus.i_res_data    = i_res_data_q;
    assign bus.i_res_ready   = i_res_ready_q;
    assign bus.d_res_data    = d_res_data_q;
    assign bus.d_res_ready   = d_res_ready_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_req_arbiter;

    localparam int AW   = 27;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one outstanding transaction, a one-cycle cool-down
    // after each completion, and a count of data grants taken while fetch waited.
    logic          m_busy, m_cool, m_owner_d;
    int            m_dwins;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, exp_i_dat, exp_d_dat;
    logic          exp_rw, exp_valid, exp_gd, exp_i_rdy, exp_d_rdy;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_cool <= 1'b0; m_owner_d <= 1'b0; m_dwins <= 0;
            exp_addr <= '0; exp_data <= '0; exp_rw <= 1'b0; exp_valid <= 1'b0;
            exp_gd <= 1'b0; exp_i_rdy <= 1'b0; exp_d_rdy <= 1'b0;
            exp_i_dat <= '0; exp_d_dat <= '0;
        end else begin
            exp_i_rdy <= 1'b0;
            exp_d_rdy <= 1'b0;
            if (m_busy) begin
                if (bus.mem_res_ready) begin
                    m_busy    <= 1'b0;
                    m_cool    <= 1'b1;
                    exp_valid <= 1'b0;
                    if (m_owner_d) begin
                        exp_d_rdy <= 1'b1; exp_d_dat <= bus.mem_res_data;
                    end else begin
                        exp_i_rdy <= 1'b1; exp_i_dat <= bus.mem_res_data;
                    end
                end
            end else if (m_cool) begin
                m_cool <= 1'b0;
            end else if (bus.d_req_valid && !(bus.i_req_valid && m_dwins >= MAXB)) begin
                m_busy <= 1'b1; m_owner_d <= 1'b1;
                exp_addr <= bus.d_req_addr; exp_data <= bus.d_req_data;
                exp_rw <= bus.d_req_rw; exp_valid <= 1'b1; exp_gd <= 1'b1;
                m_dwins <= bus.i_req_valid ? m_dwins + 1 : 0;
            end else if (bus.i_req_valid) begin
                m_busy <= 1'b1; m_owner_d <= 1'b0;
                exp_addr <= bus.i_req_addr; exp_data <= '0;
                exp_rw <= 1'b0; exp_valid <= 1'b1; exp_gd <= 1'b0;
                m_dwins <= 0;
            end else begin
                m_dwins <= 0;
            end
        end
    end

    // Environment controls
    logic          chk_en = 1'b0, rand_on = 1'b0;
    logic          cache_on = 1'b0, cache_rand = 1'b0, cache_stray = 1'b0;
    int            cache_lat = 1;
    logic [DW-1:0] cache_data = '0;
    logic          c_seen = 1'b0;
    int            c_wait = 0;
    logic          prev_valid = 1'b0;
    logic          grant_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_valid));
        chk("mem_req_addr",  32'(bus.mem_req_addr),  32'(exp_addr));
        chk("mem_req_data",  32'(bus.mem_req_data),  32'(exp_data));
        chk("mem_req_rw",    32'(bus.mem_req_rw),    32'(exp_rw));
        chk("grant_d",       32'(bus.grant_d),       32'(exp_gd));
        chk("i_res_ready",   32'(bus.i_res_ready),   32'(exp_i_rdy));
        chk("d_res_ready",   32'(bus.d_res_ready),   32'(exp_d_rdy));
        if (exp_i_rdy) chk("i_res_data", 32'(bus.i_res_data), 32'(exp_i_dat));
        if (exp_d_rdy) chk("d_res_data", 32'(bus.d_res_data), 32'(exp_d_dat));
    endtask

    task automatic drive_cache();
        bus.mem_res_ready = 1'b0;
        if (!cache_on) begin
            c_seen = 1'b0;
        end else if (bus.mem_req_valid) begin
            if (!c_seen) begin
                c_seen = 1'b1;
                c_wait = (cache_lat > 0) ? cache_lat - 1 : int'($urandom_range(0, 3));
            end
            if (c_wait == 0) begin
                bus.mem_res_ready = 1'b1;
                bus.mem_res_data  = cache_rand ? DW'($urandom) : cache_data;
            end else begin
                c_wait--;
            end
        end else begin
            c_seen = 1'b0;
            if (cache_stray && $urandom_range(0, 3) == 0) begin
                bus.mem_res_ready = 1'b1;
                bus.mem_res_data  = DW'($urandom);
            end
        end
    endtask

    task automatic drive_reqs();
        if (bus.i_res_ready || (!bus.i_req_valid && $urandom_range(0, 2) == 0)) begin
            bus.i_req_valid = bus.i_res_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_req_addr  = AW'($urandom);
        end
        if (bus.d_res_ready || (!bus.d_req_valid && $urandom_range(0, 2) == 0)) begin
            bus.d_req_valid = bus.d_res_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.d_req_addr  = AW'($urandom);
            bus.d_req_data  = DW'($urandom);
            bus.d_req_rw    = 1'($urandom_range(0, 1));
        end
    endtask

    // One cycle: outputs are checked on the falling edge, then inputs updated.
    task automatic tick();
        @(negedge sys_clk);
        if (chk_en) check_model();
        if (bus.mem_req_valid && !prev_valid) grant_q.push_back(bus.grant_d);
        prev_valid = bus.mem_req_valid;
        drive_cache();
        if (rand_on) drive_reqs();
    endtask

    task automatic idle(input int n);
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Ticks until the chosen response pulse is visible; returns ticks used or -1.
    task automatic wait_pulse(input string nm, input logic is_d, input int budget, output int used);
        used = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if ((is_d && bus.d_res_ready) || (!is_d && bus.i_res_ready)) begin
                used = k;
                break;
            end
        end
        if (used < 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no response pulse within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        logic exp_ord;
        bus.i_req_addr = '0; bus.i_req_valid = 1'b0;
        bus.d_req_addr = '0; bus.d_req_data = '0; bus.d_req_rw = 1'b0; bus.d_req_valid = 1'b0;
        bus.mem_res_data = '0; bus.mem_res_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst mem_req_addr",  32'(bus.mem_req_addr),  32'd0);
        chk("rst grant_d",       32'(bus.grant_d),       32'd0);
        chk("rst i_res_ready",   32'(bus.i_res_ready),   32'd0);
        chk("rst d_res_data",    32'(bus.d_res_data),    32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Instruction read, cache answers 5 cycles after grant
        cache_on = 1'b1; cache_lat = 5; cache_rand = 1'b0; cache_data = 32'hDEADBEEF;
        bus.i_req_addr = 27'h0000100; bus.i_req_valid = 1'b1;
        tick();
        chk("ird valid",  32'(bus.mem_req_valid), 32'd1);
        chk("ird rw",     32'(bus.mem_req_rw),    32'd0);
        chk("ird addr",   32'(bus.mem_req_addr),  32'h100);
        chk("ird grantd", 32'(bus.grant_d),       32'd0);
        wait_pulse("ird pulse", 1'b0, 20, used);
        chk("ird latency", 32'(used),           32'd5);
        chk("ird data",    32'(bus.i_res_data), 32'hDEADBEEF);
        chk("ird d_ready", 32'(bus.d_res_ready), 32'd0);
        bus.i_req_valid = 1'b0;
        tick();
        chk("ird one-shot", 32'(bus.i_res_ready), 32'd0);
        idle(3);

        // Data write held stable until completion
        cache_lat = 3; cache_data = 32'h0BADF00D;
        bus.d_req_addr = 27'h7FFFFFF; bus.d_req_data = 32'h12345678;
        bus.d_req_rw = 1'b1; bus.d_req_valid = 1'b1;
        used = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.d_res_ready) begin used = k; break; end
            chk("dwr valid", 32'(bus.mem_req_valid), 32'd1);
            chk("dwr addr",  32'(bus.mem_req_addr),  32'h7FFFFFF);
            chk("dwr data",  32'(bus.mem_req_data),  32'h12345678);
            chk("dwr rw",    32'(bus.mem_req_rw),    32'd1);
        end
        chk("dwr completed", 32'(used >= 0), 32'd1);
        chk("dwr drop", 32'(bus.mem_req_valid), 32'd0);
        bus.d_req_valid = 1'b0;
        tick();
        chk("dwr gap low", 32'(bus.mem_req_valid), 32'd0);
        chk("dwr one-shot", 32'(bus.d_res_ready), 32'd0);
        idle(3);

        // Simultaneous requests: data first, fetch 3 cycles after completion
        cache_lat = 2;
        bus.i_req_addr = 27'h200; bus.i_req_valid = 1'b1;
        bus.d_req_addr = 27'h300; bus.d_req_rw = 1'b0; bus.d_req_valid = 1'b1;
        tick();
        chk("sim grant_d", 32'(bus.grant_d),      32'd1);
        chk("sim addr",    32'(bus.mem_req_addr), 32'h300);
        wait_pulse("sim d pulse", 1'b1, 20, used);
        bus.d_req_valid = 1'b0;
        used = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.mem_req_valid) begin used = k; break; end
        end
        chk("sim turnaround", 32'(used),            32'd2);
        chk("sim i grant",    32'(bus.grant_d),     32'd0);
        chk("sim i addr",     32'(bus.mem_req_addr), 32'h200);
        wait_pulse("sim i pulse", 1'b0, 20, used);
        idle(3);

        // Starvation bound: both held, expected order D,D,D,D,I,D,D,D,D,I
        grant_q.delete();
        bus.i_req_valid = 1'b1; bus.d_req_valid = 1'b1;
        for (int k = 0; k < 200 && grant_q.size() < 10; k++) tick();
        chk("starve grants", 32'(grant_q.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < grant_q.size(); k++) begin
            exp_ord = (k == 4 || k == 9) ? 1'b0 : 1'b1;
            chk($sformatf("starve order[%0d]", k), 32'(grant_q[k]), 32'(exp_ord));
        end
        idle(12);

        // Stray completion in IDLE
        cache_on = 1'b0;
        bus.mem_res_data = 32'hAAAA5555; bus.mem_res_ready = 1'b1;
        tick();
        chk("stray idle i", 32'(bus.i_res_ready),   32'd0);
        chk("stray idle d", 32'(bus.d_res_ready),   32'd0);
        chk("stray idle v", 32'(bus.mem_req_valid), 32'd0);

        // Stray completion in GAP, then a request that must still see normal turnaround
        cache_on = 1'b1; cache_lat = 1;
        bus.i_req_addr = 27'h400; bus.i_req_valid = 1'b1;
        wait_pulse("gap i pulse", 1'b0, 20, used);
        cache_on = 1'b0;
        bus.i_req_addr = 27'h404;
        bus.mem_res_data = 32'h77777777; bus.mem_res_ready = 1'b1;
        tick();
        chk("stray gap i", 32'(bus.i_res_ready),   32'd0);
        chk("stray gap v", 32'(bus.mem_req_valid), 32'd0);
        tick();
        chk("post gap grant", 32'(bus.mem_req_valid), 32'd1);
        chk("post gap addr",  32'(bus.mem_req_addr),  32'h404);
        bus.mem_res_data = 32'h00000055; bus.mem_res_ready = 1'b1;
        tick();
        chk("manual i data", 32'(bus.i_res_data), 32'h55);
        idle(3);

        // Asynchronous reset mid-BUSY_D, pending fetch served after release
        bus.d_req_addr = 27'h500; bus.d_req_data = 32'hCAFE0001; bus.d_req_rw = 1'b1; bus.d_req_valid = 1'b1;
        tick();
        bus.i_req_addr = 27'h600; bus.i_req_valid = 1'b1;
        tick();
        #2;
        rst = 1'b1; bus.d_req_valid = 1'b0;
        #1;
        chk("arst valid",  32'(bus.mem_req_valid), 32'd0);
        chk("arst addr",   32'(bus.mem_req_addr),  32'd0);
        chk("arst data",   32'(bus.mem_req_data),  32'd0);
        chk("arst rw",     32'(bus.mem_req_rw),    32'd0);
        chk("arst grantd", 32'(bus.grant_d),       32'd0);
        chk("arst i_data", 32'(bus.i_res_data),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post rst valid", 32'(bus.mem_req_valid), 32'd1);
        chk("post rst owner", 32'(bus.grant_d),       32'd0);
        chk("post rst addr",  32'(bus.mem_req_addr),  32'h600);
        bus.mem_res_data = 32'h13572468; bus.mem_res_ready = 1'b1;
        tick();
        chk("post rst i pulse", 32'(bus.i_res_ready), 32'd1);
        idle(3);

        // Randomized traffic against the model
        cache_on = 1'b1; cache_lat = 0; cache_rand = 1'b1; cache_stray = 1'b1;
        rand_on = 1'b1;
        for (int k = 0; k < 3000; k++) tick();
        rand_on = 1'b0; cache_stray = 1'b0;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
